calc_disp_scan: RTL and testbench

- Display back-end of the 4-bit calculator. Sits directly downstream of the ALU/result selector.
- On a load strobe it captures both operands, the 8-bit result and the sign, then converts the result to BCD sequentially (double-dabble).
- It time-multiplexes six common-anode 7-segment digits with active-low digit selects.
- The previously committed values stay on display until a conversion finishes, so the display never flickers.

---
 rtl/calc_disp_pkg.sv | 41 ++++
 rtl/calc_disp_scan_hex7_glyph.sv | 49 ++++
 rtl/calc_disp_scan.sv | 224 ++++++++++++++++++++++
 tb/tb_calc_disp_scan.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// ---------------------------------------------------------------------------
// calc_disp_pkg
// Shared types and constants for the calculator display back-end.
//   state_t       : conversion FSM states (IDLE / SHIFT / COMMIT)
//   NDIG          : number of multiplexed 7-segment digits
//   SEG_BLANK     : all segments off (active-low)
//   SEG_MINUS     : only segment g lit, used as the sign digit
//   DIGSEL_TAB    : active-low one-hot digit select per scan index
//   dabble_adjust : add-3 correction applied before each double-dabble shift
// ---------------------------------------------------------------------------
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NDIG = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [5:0] DIGSEL_TAB [NDIG] = '{
    6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111
  };

  // Every BCD nibble that is 5 or more gets +3 so that the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int i = 0; i < 3; i++) begin
      if (res[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/calc_disp_scan_hex7_glyph.sv
// ---------------------------------------------------------------------------
// hex7_glyph
// Combinational lookup from a 4-bit hex code to active-low 7-segment pattern
// (bit6 = g .. bit0 = a). The minus flag wins over blank, which wins over
// the hex glyph.
//   code_i  : hex code 0..F
//   blank_i : force all segments off
//   minus_i : force the minus glyph
//   seg_o   : active-low segment pattern
// ---------------------------------------------------------------------------
module hex7_glyph
  import calc_disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       minus_i,
  output logic [6:0] seg_o
);

  // Glyph table first, then the blank/minus overrides on top of it.
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_BLANK;
    endcase
    if (minus_i) begin
      seg_o = SEG_MINUS;
    end else if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/calc_disp_scan.sv
// ---------------------------------------------------------------------------
// calc_disp_scan
// Display back-end of the 4-bit calculator. A load in IDLE captures the
// operands, result and sign, converts the result to BCD with an 8-step
// double-dabble, then commits everything to the display register in one
// cycle. Six common-anode digits are time-multiplexed from that register.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   load   : capture request, only honoured in IDLE
//   a, b   : operands, shown as hex on digits 0 and 1
//   value  : unsigned result magnitude 0..255
//   neg    : result sign, shown as minus on digit 2
//   busy   : conversion in progress
//   done   : one-cycle pulse after the display register is committed
//   seg    : active-low segments, bit6 = g .. bit0 = a
//   digsel : active-low one-hot digit select, bit0 = leftmost digit
// Build option: define LZ_BLANK_EN to blank leading zeros of the hundreds
// and tens digits.
// ---------------------------------------------------------------------------
module calc_disp_scan
  import calc_disp_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [7:0] value,
  input  logic       neg,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [5:0] digsel
);

  state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  pendA_q, pendA_d, pendB_q, pendB_d;
  logic        pendNeg_q, pendNeg_d;
  logic [3:0]  dispA_q, dispA_d, dispB_q, dispB_d;
  logic        dispNeg_q, dispNeg_d;
  logic [11:0] dispBcd_q, dispBcd_d;
  logic        done_q, done_d;

  logic [DIV_W-1:0] prescaler_q;
  logic [2:0]       idx_q;
  logic [6:0]       seg_q;
  logic [5:0]       digsel_q;

  logic       tick;
  logic [3:0] glyphCode;
  logic       glyphBlank;
  logic       glyphMinus;
  logic [6:0] glyphSeg;
  logic [5:0] digselNext;

  // Conversion FSM: IDLE waits for load, SHIFT runs eight double-dabble
  // steps, COMMIT copies the finished result into the display register.
  // The display register only changes in COMMIT, so the scan never shows a
  // half-converted number.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    pendA_d   = pendA_q;
    pendB_d   = pendB_q;
    pendNeg_d = pendNeg_q;
    dispA_d   = dispA_q;
    dispB_d   = dispB_q;
    dispNeg_d = dispNeg_q;
    dispBcd_d = dispBcd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d   = value;
          pendA_d   = a;
          pendB_d   = b;
          pendNeg_d = neg;
          bcd_d     = 12'd0;
          iter_d    = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shift_d} = {dabble_adjust(bcd_q), shift_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        dispA_d   = pendA_q;
        dispB_d   = pendB_q;
        dispNeg_d = pendNeg_q;
        dispBcd_d = bcd_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion and display registers; reset also clears what is displayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 8'd0;
      bcd_q     <= 12'd0;
      iter_q    <= 3'd0;
      pendA_q   <= 4'd0;
      pendB_q   <= 4'd0;
      pendNeg_q <= 1'b0;
      dispA_q   <= 4'd0;
      dispB_q   <= 4'd0;
      dispNeg_q <= 1'b0;
      dispBcd_q <= 12'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      pendA_q   <= pendA_d;
      pendB_q   <= pendB_d;
      pendNeg_q <= pendNeg_d;
      dispA_q   <= dispA_d;
      dispB_q   <= dispB_d;
      dispNeg_q <= dispNeg_d;
      dispBcd_q <= dispBcd_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  // Pick what the current scan index should show. Digit 2 is the sign, the
  // last three are hundreds/tens/units from the committed BCD.
  always_comb begin
    glyphCode  = 4'd0;
    glyphBlank = 1'b0;
    glyphMinus = 1'b0;
    digselNext = 6'b111111;
    case (idx_q)
      3'd0: begin
        glyphCode  = dispA_q;
        digselNext = DIGSEL_TAB[0];
      end
      3'd1: begin
        glyphCode  = dispB_q;
        digselNext = DIGSEL_TAB[1];
      end
      3'd2: begin
        glyphMinus = dispNeg_q;
        glyphBlank = ~dispNeg_q;
        digselNext = DIGSEL_TAB[2];
      end
      3'd3: begin
        glyphCode  = dispBcd_q[11:8];
`ifdef LZ_BLANK_EN
        glyphBlank = (dispBcd_q[11:8] == 4'd0);
`else
        glyphBlank = 1'b0;
`endif
        digselNext = DIGSEL_TAB[3];
      end
      3'd4: begin
        glyphCode  = dispBcd_q[7:4];
`ifdef LZ_BLANK_EN
        glyphBlank = (dispBcd_q[11:4] == 8'd0);
`else
        glyphBlank = 1'b0;
`endif
        digselNext = DIGSEL_TAB[4];
      end
      3'd5: begin
        glyphCode  = dispBcd_q[3:0];
        digselNext = DIGSEL_TAB[5];
      end
      default: begin
        glyphBlank = 1'b1;
        digselNext = 6'b111111;
      end
    endcase
  end

  hex7_glyph u_glyph (
    .code_i  (glyphCode),
    .blank_i (glyphBlank),
    .minus_i (glyphMinus),
    .seg_o   (glyphSeg)
  );

  assign tick = &prescaler_q;

  // Free-running prescaler; on each tick the selected digit is registered
  // and the index wraps 5 -> 0. A commit landing on a tick edge is not seen
  // until the next tick because the mux reads the pre-commit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= 3'd0;
      seg_q       <= SEG_BLANK;
      digsel_q    <= 6'b111111;
    end else begin
      prescaler_q <= prescaler_q + 1'b1;
      if (tick) begin
        seg_q    <= glyphSeg;
        digsel_q <= digselNext;
        idx_q    <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
    end
  end

  assign seg    = seg_q;
  assign digsel = digsel_q;

endmodule

// File: tb/tb_calc_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_calc_disp_scan
// Directed self-checking bench for calc_disp_scan with DIV_W = 2. Expected
// glyphs come from a hand-written hex table and hand-computed BCD digits.
// Honours LZ_BLANK_EN for the hundreds/tens expectations.
// ---------------------------------------------------------------------------
module tb_calc_disp_scan;

  localparam int DIV_W = 2;

  localparam logic [6:0] G [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [5:0] DSEL [6] = '{
    6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [7:0] value = 8'd0;
  logic       neg = 1'b0;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [5:0] digsel;

  int total = 0;
  int bad = 0;
  logic [6:0] frame [6];

  calc_disp_scan #(.DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .a      (a),
    .b      (b),
    .value  (value),
    .neg    (neg),
    .busy   (busy),
    .done   (done),
    .seg    (seg),
    .digsel (digsel)
  );

  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected hundreds glyph, honouring leading-zero blanking.
  function automatic logic [6:0] expH(input int h);
`ifdef LZ_BLANK_EN
    return (h == 0) ? BLANK : G[h];
`else
    return G[h];
`endif
  endfunction

  // Expected tens glyph, honouring leading-zero blanking.
  function automatic logic [6:0] expT(input int h, input int t);
`ifdef LZ_BLANK_EN
    return (h == 0 && t == 0) ? BLANK : G[t];
`else
    return G[t];
`endif
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Watch the scan until every digit position has been seen once.
  task automatic captureFrame(input string tag);
    logic [5:0] seen;
    seen = 6'd0;
    for (int k = 0; k < 6; k++) frame[k] = 7'h00;
    for (int c = 0; c < 100 && seen != 6'h3F; c++) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
        if (digsel == DSEL[k]) begin
          frame[k] = seg;
          seen[k]  = 1'b1;
        end
      end
    end
    checkOutput({tag, "_frame_seen"}, {26'd0, seen}, 32'h3F);
  endtask

  // Capture one scan frame and compare all six digits.
  task automatic checkFrame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3,
                            input logic [6:0] e4, input logic [6:0] e5);
    logic [6:0] e [6];
    e = '{e0, e1, e2, e3, e4, e5};
    captureFrame(tag);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("%s_d%0d", tag, k), {25'd0, frame[k]}, {25'd0, e[k]});
    end
  endtask

  // One load pulse from IDLE; checks busy length and a single done pulse.
  task automatic applyStimulus(input string tag, input logic [3:0] aV, input logic [3:0] bV,
                               input logic [7:0] vV, input logic nV);
    int busyCnt;
    int doneCnt;
    busyCnt = 0;
    doneCnt = 0;
    @(negedge clk);
    a = aV; b = bV; value = vV; neg = nV; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy) busyCnt++;
      if (done) doneCnt++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, busyCnt, 9);
    checkOutput({tag, "_done_pulses"}, doneCnt, 1);
  endtask

  initial begin
    int dc;
    int c;
    bit got;

    $display("[TB] start");
    // Reset behaviour and asynchronous assertion mid-run
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_seg", {25'd0, seg}, 32'h7F);
    checkOutput("rst_digsel", {26'd0, digsel}, 32'h3F);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (digsel != 6'h3F) got = 1;
    end
    checkOutput("first_tick_seen", {31'd0, got}, 1);
    checkOutput("first_tick_digsel", {26'd0, digsel}, 32'h3E);
    checkOutput("first_tick_seg", {25'd0, seg}, {25'd0, G[0]});

    // value 156, a=C, b=3, positive
    applyStimulus("v156", 4'hC, 4'h3, 8'd156, 1'b0);
    checkFrame("v156", G[12], G[3], BLANK, G[1], G[5], G[6]);

    // value 7, negative
    applyStimulus("v7n", 4'h7, 4'hA, 8'd7, 1'b1);
    checkFrame("v7n", G[7], G[10], MINUS, expH(0), expT(0, 0), G[7]);

    // boundaries
    applyStimulus("v255", 4'hF, 4'h0, 8'd255, 1'b0);
    checkFrame("v255", G[15], G[0], BLANK, G[2], G[5], G[5]);
    applyStimulus("v0", 4'h8, 4'hD, 8'd0, 1'b0);
    checkFrame("v0", G[8], G[13], BLANK, expH(0), expT(0, 0), G[0]);

    // load during SHIFT is ignored
    @(negedge clk);
    a = 4'h1; b = 4'h2; value = 8'd42; neg = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    a = 4'hF; b = 4'hF; value = 8'd99; neg = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    dc = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    checkOutput("ignore_done_pulses", dc, 1);
    checkFrame("ignore", G[1], G[2], BLANK, expH(0), expT(0, 4), G[2]);

    // load on the cycle after done is accepted
    @(negedge clk);
    a = 4'h4; b = 4'h5; value = 8'd100; neg = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    got = 0;
    for (c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    checkOutput("b2b_first_done", {31'd0, got}, 1);
    a = 4'h9; b = 4'hE; value = 8'd200; neg = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checkOutput("b2b_accept_busy", {31'd0, busy}, 1);
    got = 0;
    for (c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    checkOutput("b2b_second_done", {31'd0, got}, 1);
    checkFrame("b2b", G[9], G[14], MINUS, G[2], G[0], G[0]);

    // reset during SHIFT iteration 4
    @(negedge clk);
    a = 4'h3; b = 4'h7; value = 8'd123; neg = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    checkOutput("midrst_done_pulses", dc, 0);
    checkFrame("midrst", G[0], G[0], BLANK, expH(0), expT(0, 0), G[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
